if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage_imem.sv | 23 ++
 rtl/if_stage.sv | 74 +++++++
 tb/tb_if_stage.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants and types shared by the pipeline stages.
//   INSTR_W   - instruction word width
//   PC_INC    - sequential fetch increment, in bytes
//   NOP_WORD  - bubble encoding (AL condition, all other fields zero); the
//               decode stage also uses it to recognise bubbles
//   if_id_t   - contents of the IF/ID pipeline register
//   rom_word  - instruction ROM image, one word per index
package if_stage_pkg;

    localparam int          INSTR_W  = 32;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'hE000_0000;

    typedef struct packed {
        logic [31:0]        pc;     // PC+4 of the held instruction
        logic [INSTR_W-1:0] instr;  // fetched word or NOP_WORD
        logic               valid;  // 0 marks an inserted bubble
    } if_id_t;

    // Bring-up boot image: word i holds 0x100 + i, so every fetched word
    // identifies the word address it came from.
    function automatic logic [INSTR_W-1:0] rom_word(input int unsigned idx);
        return 32'h100 + idx;
    endfunction

endpackage

// File: rtl/if_stage_imem.sv
// InstructionMemory: read-only instruction store with a combinational read.
//   addr - word index (byte address bits [AW+1:2] of the fetch PC)
//   word - instruction word at that index
// Contents come from the package boot image; there is no write port.
module InstructionMemory
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]      addr,
    output logic [INSTR_W-1:0] word
);

    logic [INSTR_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = rom_word(i);
    end

    assign word = rom[addr];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with the IF/ID pipeline register.
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   freeze       - stall from hazard detection; holds PC and IF/ID
//   Branch_taken - branch resolved taken in EXE; redirect and flush IF/ID
//   BranchAddr   - branch target byte address (used as-is, not realigned)
//   PC           - registered PC+4 of the instruction held in IF/ID
//   Instruction  - registered instruction word for decode
//   IF_valid     - 1 = fetched word, 0 = bubble
// All outputs come straight from flops, so control inputs never reach an
// output combinationally.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] NOP_WORD   = if_stage_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               Branch_taken,
    input  logic [31:0]        BranchAddr,
    output logic [31:0]        PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               IF_valid
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0]        pc_q;
    logic [31:0]        pc_next_seq;
    logic [INSTR_W-1:0] fetch_word;
    if_id_t             if_id_q;

    // Wraps naturally modulo 2^32.
    assign pc_next_seq = pc_q + PC_INC;

    // Byte-offset bits and bits above the memory size are dropped, so
    // addresses alias modulo 4*IMEM_DEPTH.
    InstructionMemory #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .addr (pc_q[AW+1:2]),
        .word (fetch_word)
    );

    // Branch beats freeze: a taken branch must not be lost to a stall.
    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= '0;
        else if (Branch_taken)
            pc_q <= BranchAddr;
        else if (!freeze)
            pc_q <= pc_next_seq;
    end

    always_ff @(posedge clk) begin
        if (rst || Branch_taken) begin
            if_id_q.pc    <= '0;
            if_id_q.instr <= NOP_WORD;
            if_id_q.valid <= 1'b0;
        end else if (!freeze) begin
            if_id_q.pc    <= pc_next_seq;
            if_id_q.instr <= fetch_word;
            if_id_q.valid <= 1'b1;
        end
    end

    assign PC          = if_id_q.pc;
    assign Instruction = if_id_q.instr;
    assign IF_valid    = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, scoreboard-checked bench for if_stage.
// Each step drives one cycle of inputs, pushes the IF/ID contents a
// reference model predicts for the following edge, then pops and compares
// after that edge.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] BranchAddr = '0;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        IF_valid;

    if_stage #(.IMEM_DEPTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (Branch_taken),
        .BranchAddr   (BranchAddr),
        .PC           (PC),
        .Instruction  (Instruction),
        .IF_valid     (IF_valid)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    if_id_t      sb_q[$];
    logic [31:0] m_pc;   // model fetch PC
    if_id_t      m_out;  // model IF/ID contents

    function automatic logic [31:0] exp_rom(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr >> 2) & 32'd63;
        return 32'h100 + idx;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic b,
                        input logic f, input logic [31:0] a);
        if_id_t e;
        rst = r; Branch_taken = b; freeze = f; BranchAddr = a;
        if (r || b) begin
            m_out.pc = '0; m_out.instr = 32'hE000_0000; m_out.valid = 1'b0;
            m_pc = r ? 32'd0 : a;
        end else if (!f) begin
            m_out.pc = m_pc + 32'd4; m_out.instr = exp_rom(m_pc); m_out.valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        sb_q.push_back(m_out);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            compared++; mismatched++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check32({tag, ".PC"}, PC, e.pc);
            check32({tag, ".Instruction"}, Instruction, e.instr);
            check1({tag, ".IF_valid"}, IF_valid, e.valid);
        end
    endtask

    initial begin
        m_pc = '0;
        m_out.pc = '0; m_out.instr = 32'hE000_0000; m_out.valid = 1'b0;
        @(negedge clk);

        // reset state, then four free-running fetches
        step("rst0", 1, 0, 0, 0);
        step("rst1", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step($sformatf("free%0d", i), 0, 0, 0, 0);

        // stall while PC=8 holds everything, release continues at 12
        step("rst2", 1, 0, 0, 0);
        step("f4", 0, 0, 0, 0);
        step("f8", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("frz%0d", i), 0, 0, 1, 0);
        step("rel", 0, 0, 0, 0);

        // taken branch flushes, fetch resumes at target
        step("br20", 0, 1, 0, 32'h20);
        step("br20n", 0, 0, 0, 0);
        step("br20nn", 0, 0, 0, 0);

        // branch wins over freeze in the same cycle
        step("brfrz40", 0, 1, 1, 32'h40);
        step("brfrz40n", 0, 0, 0, 0);

        // end of memory, aliasing back to word 0
        step("brFC", 0, 1, 0, 32'hFC);
        step("brFCn", 0, 0, 0, 0);
        step("brFCnn", 0, 0, 0, 0);

        // back-to-back branches stay flushed, last target wins
        step("bb10", 0, 1, 0, 32'h10);
        step("bb30", 0, 1, 0, 32'h30);
        step("bbn", 0, 0, 0, 0);

        // unaligned target is not realigned
        step("br22", 0, 1, 0, 32'h22);
        step("br22n", 0, 0, 0, 0);

        // 32-bit wrap of the fetch PC
        step("brTop", 0, 1, 0, 32'hFFFF_FFFC);
        step("wrap0", 0, 0, 0, 0);
        step("wrap1", 0, 0, 0, 0);

        // reset during a stall discards state and restarts at 0
        step("pfrz", 0, 0, 1, 0);
        step("rstfrz", 1, 0, 1, 0);
        step("post0", 0, 0, 0, 0);
        step("post1", 0, 0, 0, 0);

        // reset beats a simultaneous branch
        step("rstbr", 1, 1, 0, 32'h80);
        step("post2", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
